// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit bus writer: timed setup, E pulse, hold and busy wait per nibble.
// Define LCD_NIBBLE_WRITER_INIT_EN to issue the 3,3,3,2 init nibbles after power-up.
module lcd_nibble_writer #(
  parameter int T_AS      = 2,
  parameter int T_PW      = 6,
  parameter int T_H       = 2,
  parameter int WAIT_DATA = 600,
  parameter int WAIT_CMD  = 20000,
  parameter int T_POWERUP = 180000,
  parameter int CW        = 18
) (
  input  logic       refclk,
  input  logic       nreset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] lcd_dq,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic       busy,
  output logic [7:0] nib_count
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_e;

  localparam logic [CW-1:0] LIM_AS  = CW'(T_AS - 1);
  localparam logic [CW-1:0] LIM_PW  = CW'(T_PW - 1);
  localparam logic [CW-1:0] LIM_H   = CW'(T_H - 1);
  localparam logic [CW-1:0] LIM_DAT = CW'(WAIT_DATA - 1);
  localparam logic [CW-1:0] LIM_CMD = CW'(WAIT_CMD - 1);
  localparam logic [CW-1:0] LIM_PWR = CW'(T_POWERUP - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wait_lim;
  logic [3:0]    dq_q, dq_d;
  logic          rs_q, rs_d;
  logic          e_q, e_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic [7:0]    nib_q, nib_d;
  logic          unused_bits;

  assign unused_bits = ^in_data[2:1];

`ifdef LCD_NIBBLE_WRITER_INIT_EN
  logic [1:0] init_idx_q, init_idx_d;
  logic       init_done_q, init_done_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    dq_d     = dq_q;
    rs_d     = rs_q;
    e_d      = 1'b0;
    nib_d    = nib_q;
    wait_lim = rs_q ? LIM_DAT : LIM_CMD;
`ifdef LCD_NIBBLE_WRITER_INIT_EN
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
`endif
    unique case (state_q)
      S_PWRUP: begin
        if (cnt_q == LIM_PWR) begin
`ifdef LCD_NIBBLE_WRITER_INIT_EN
          state_d = S_INIT;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef LCD_NIBBLE_WRITER_INIT_EN
      S_INIT: begin
        dq_d       = (init_idx_q == 2'd3) ? 4'h2 : 4'h3;
        rs_d       = 1'b0;
        init_idx_d = init_idx_q + 2'd1;
        if (init_idx_q == 2'd3) init_done_d = 1'b1;
        state_d    = S_SETUP;
      end
`endif
      S_IDLE: begin
        if (in_valid && ready_q && !in_data[0]) begin
          dq_d    = in_data[7:4];
          rs_d    = in_data[3];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == LIM_AS) begin
          e_d     = 1'b1;
          nib_d   = nib_q + 8'd1;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        e_d = 1'b1;
        if (cnt_q == LIM_PW) begin
          e_d     = 1'b0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == LIM_H) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == wait_lim) begin
`ifdef LCD_NIBBLE_WRITER_INIT_EN
          state_d = init_done_q ? S_IDLE : S_INIT;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_PWRUP;
    endcase
    // Every state change restarts the per-state timer
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge refclk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      dq_q    <= 4'h0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      nib_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      nib_q   <= nib_d;
    end
  end

`ifdef LCD_NIBBLE_WRITER_INIT_EN
  always_ff @(posedge refclk or negedge nreset) begin
    if (!nreset) begin
      init_idx_q  <= 2'd0;
      init_done_q <= 1'b0;
    end else begin
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
    end
  end
`endif

  assign in_ready  = ready_q;
  assign lcd_dq    = dq_q;
  assign lcd_rs    = rs_q;
  assign lcd_e     = e_q;
  assign busy      = busy_q;
  assign nib_count = nib_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer with short timing parameters.
// Covers power-up, data/cmd writes, non-LCD bytes, reset mid-pulse and optional init.
module tb_lcd_nibble_writer;

  logic       refclk;
  logic       nreset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] lcd_dq;
  logic       lcd_rs;
  logic       lcd_e;
  logic       busy;
  logic [7:0] nib_count;

  int checks;
  int fails;
  int nib_exp;

  lcd_nibble_writer #(
    .T_AS(2), .T_PW(3), .T_H(1),
    .WAIT_DATA(5), .WAIT_CMD(20),
    .T_POWERUP(10), .CW(18)
  ) dut (
    .refclk(refclk),
    .nreset(nreset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .lcd_dq(lcd_dq),
    .lcd_rs(lcd_rs),
    .lcd_e(lcd_e),
    .busy(busy),
    .nib_count(nib_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b1;
    #3;
    nreset = 1'b0;
    #1;
    checks++;
    if (lcd_e !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_ctl: e=%b rdy=%b busy=%b, want 0 0 1",
               lcd_e, in_ready, busy);
    end
    checks++;
    if (lcd_dq !== 4'h0 || lcd_rs !== 1'b0 || nib_count !== 8'h00) begin
      fails++;
      $display("FAIL reset_bus: dq=%h rs=%b nib=%0d, want 0 0 0",
               lcd_dq, lcd_rs, nib_count);
    end
    step();
    step();
    checks++;
    if (in_ready !== 1'b0 || lcd_e !== 1'b0) begin
      fails++;
      $display("FAIL reset_held: rdy=%b e=%b, want 0 0", in_ready, lcd_e);
    end
    nreset = 1'b1;
  endtask

  // Called right after reset release, #1 after a clock edge.
  task automatic test_powerup(input logic hold_valid);
    int last;
    logic rdy_exp;
    logic e_exp;
    int m;
    int idx;
    in_data  = 8'h01;
    in_valid = hold_valid;
`ifdef LCD_NIBBLE_WRITER_INIT_EN
    last = 118;
`else
    last = 10;
`endif
    for (int n = 1; n <= last; n++) begin
      step();
      rdy_exp = (n == last);
      e_exp   = 1'b0;
`ifdef LCD_NIBBLE_WRITER_INIT_EN
      if (n >= 11) begin
        idx = (n - 11) / 27;
        m   = (n - 11) % 27;
        e_exp = (m >= 2 && m <= 4);
        checks++;
        if (lcd_dq !== ((idx == 3) ? 4'h2 : 4'h3) || lcd_rs !== 1'b0) begin
          fails++;
          $display("FAIL init_dq: n=%0d dq=%h rs=%b, want %h 0",
                   n, lcd_dq, lcd_rs, (idx == 3) ? 4'h2 : 4'h3);
        end
      end
`else
      idx = 0;
      m   = 0;
`endif
      checks++;
      if (in_ready !== rdy_exp || busy !== !rdy_exp) begin
        fails++;
        $display("FAIL pwrup_ready: n=%0d rdy=%b busy=%b, want rdy %b",
                 n, in_ready, busy, rdy_exp);
      end
      checks++;
      if (lcd_e !== e_exp) begin
        fails++;
        $display("FAIL pwrup_e: n=%0d e=%b, want %b", n, lcd_e, e_exp);
      end
    end
    in_valid = 1'b0;
`ifdef LCD_NIBBLE_WRITER_INIT_EN
    nib_exp = 4;
`else
    nib_exp = 0;
`endif
    checks++;
    if (nib_count !== 8'(nib_exp)) begin
      fails++;
      $display("FAIL pwrup_nib: nib=%0d, want %0d", nib_count, nib_exp);
    end
  endtask

  task automatic run_write(input logic [7:0] b, input int total);
    logic e_exp;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL wr_pre_ready: rdy=%b, want 1", in_ready);
    end
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 8'hFF;
    checks++;
    if (lcd_dq !== b[7:4] || lcd_rs !== b[3] ||
        in_ready !== 1'b0 || lcd_e !== 1'b0) begin
      fails++;
      $display("FAIL wr_latch: dq=%h rs=%b rdy=%b e=%b, want %h %b 0 0",
               lcd_dq, lcd_rs, in_ready, lcd_e, b[7:4], b[3]);
    end
    nib_exp++;
    for (int n = 1; n <= total; n++) begin
      step();
      e_exp = (n >= 2 && n <= 4);
      checks++;
      if (lcd_e !== e_exp) begin
        fails++;
        $display("FAIL wr_e: n=%0d e=%b, want %b", n, lcd_e, e_exp);
      end
      checks++;
      if (in_ready !== (n == total)) begin
        fails++;
        $display("FAIL wr_ready: n=%0d rdy=%b, want %b",
                 n, in_ready, (n == total));
      end
      checks++;
      if (lcd_dq !== b[7:4] || lcd_rs !== b[3]) begin
        fails++;
        $display("FAIL wr_bus_stable: n=%0d dq=%h rs=%b, want %h %b",
                 n, lcd_dq, lcd_rs, b[7:4], b[3]);
      end
    end
    checks++;
    if (nib_count !== 8'(nib_exp)) begin
      fails++;
      $display("FAIL wr_nib: nib=%0d, want %0d", nib_count, nib_exp);
    end
  endtask

  task automatic test_data_write();
    run_write(8'h58, 11);
  endtask

  task automatic test_cmd_write();
    run_write(8'h20, 26);
  endtask

  task automatic test_non_lcd();
    in_data  = 8'h71;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (in_ready !== 1'b1 || lcd_e !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL nonlcd_ctl: n=%0d rdy=%b e=%b busy=%b, want 1 0 0",
                 n, in_ready, lcd_e, busy);
      end
      checks++;
      if (lcd_dq !== 4'h2 || lcd_rs !== 1'b0 ||
          nib_count !== 8'(nib_exp)) begin
        fails++;
        $display("FAIL nonlcd_bus: dq=%h rs=%b nib=%0d, want 2 0 %0d",
                 lcd_dq, lcd_rs, nib_count, nib_exp);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    in_data  = 8'h58;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    checks++;
    if (lcd_e !== 1'b1) begin
      fails++;
      $display("FAIL mid_e_high: e=%b, want 1", lcd_e);
    end
    nreset = 1'b0;
    #1;
    checks++;
    if (lcd_e !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_ctl: e=%b rdy=%b busy=%b, want 0 0 1",
               lcd_e, in_ready, busy);
    end
    checks++;
    if (lcd_dq !== 4'h0 || lcd_rs !== 1'b0 || nib_count !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset_bus: dq=%h rs=%b nib=%0d, want 0 0 0",
               lcd_dq, lcd_rs, nib_count);
    end
    step();
    checks++;
    if (lcd_e !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_held: e=%b rdy=%b, want 0 0",
               lcd_e, in_ready);
    end
    nreset = 1'b1;
    test_powerup(1'b0);
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    nib_exp  = 0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    test_reset();
    test_powerup(1'b1);
    test_data_write();
    test_cmd_write();
    test_non_lcd();
    test_reset_mid();
    test_data_write();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_writer.md
Name: lcd_nibble_writer

Overview:
- Downstream of the POST-box receive stage. Consumes LCD command bytes that the postcode receiver has already decoded.
- Byte format: data nibble in bits [7:4], RS in bit 3, bit 0 = 0 marks an LCD write.
- Drives an HD44780 4-bit bus with counted setup, E-pulse, hold and post-write busy timing. This replaces the free-running E-stretch and lockout monostable with a single clocked handshake.
- Runs on the 12 MHz reference clock.

Parameters:
- T_AS, 2, cycles of RS/DQ setup before E rises (minimum 1).
- T_PW, 6, cycles of E high (minimum 1).
- T_H, 2, cycles of RS/DQ hold after E falls (minimum 1).
- WAIT_DATA, 600, busy cycles after a nibble with RS=1 (50 us at 12 MHz).
- WAIT_CMD, 20000, busy cycles after a nibble with RS=0 (1.67 ms, covers clear/home).
- T_POWERUP, 180000, cycles after reset before the first write (15 ms).
- CW, 18, internal counter width; must hold the largest parameter.

Ports:
- refclk  input  1  reference clock, 12 MHz.
- nreset  input  1  asynchronous, active-low reset.
- in_data  input  8  command byte: [7:4] nibble, [3] RS, [2:1] ignored, [0] 0=LCD write / 1=not for LCD.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a byte this cycle.
- lcd_dq  output  4  LCD DB7..DB4.
- lcd_rs  output  1  LCD RS.
- lcd_e  output  1  LCD E strobe.
- busy  output  1  high in every state except IDLE.
- nib_count  output  8  count of nibbles strobed since reset; wraps 255 -> 0.

Behaviour:
- Reset (nreset low, asynchronous): state=PWRUP, counter=0, lcd_e=0, lcd_dq=0, lcd_rs=0, in_ready=0, busy=1, nib_count=0.
- All outputs are registered.
- Handshake:
  - Transfer occurs on a refclk edge where in_valid && in_ready.
  - in_ready = (state==IDLE) exactly, registered.
  - in_data is sampled only on the transfer edge.
  - in_valid while not ready is ignored; nothing is queued.
- PWRUP: count T_POWERUP cycles, then go to IDLE (or INIT with LCD_INIT_EN).
- IDLE, on transfer:
  - If in_data[0]=1: byte is consumed with no bus activity; stays in IDLE; in_ready remains 1 next cycle.
  - If in_data[0]=0: latch lcd_dq=in_data[7:4], lcd_rs=in_data[3]; go to SETUP; in_ready=0 from the next cycle.
- SETUP: E=0 for T_AS cycles, then PULSE.
- PULSE: E=1 for exactly T_PW cycles. nib_count increments on the cycle E rises. Then HOLD.
- HOLD: E=0 for T_H cycles; DQ/RS unchanged. Then WAIT.
- WAIT: WAIT_DATA cycles if the latched RS=1, else WAIT_CMD cycles. Then IDLE.
- Latency: from the transfer edge, E rises after T_AS cycles. in_ready returns after T_AS+T_PW+T_H+WAIT_x cycles.
- lcd_dq and lcd_rs hold their last values in IDLE and change only on an accepted LCD byte.
- E never rises while RS/DQ are changing; E is never high outside PULSE.
- Reset mid-operation: immediate return to reset values. E drops asynchronously, and a full T_POWERUP wait is repeated.
- Counter: counts 0 .. N-1 within each timed state and clears on every state change. No wrap-around inside a state.

Optional Feature:
- Macro LCD_NIBBLE_WRITER_INIT_EN.
- Defined:
  - After PWRUP, an INIT state autonomously writes nibbles 0x3, 0x3, 0x3, 0x2 with RS=0.
  - Each uses the normal SETUP/PULSE/HOLD sequence followed by WAIT_CMD.
  - in_ready stays 0 throughout, then IDLE is entered. nib_count = 4 on entry to IDLE.
- Undefined: PWRUP goes directly to IDLE; the host sends the 4-bit init sequence itself.

Test Plan (T_AS=2, T_PW=3, T_H=1, WAIT_DATA=5, WAIT_CMD=20, T_POWERUP=10, macro undefined unless stated):
1. Release reset, hold in_valid=1 -> in_ready=0 for 10 cycles, then 1; lcd_e=0 throughout.
2. Send 0x58 (nibble 5, RS=1) -> DQ=5, RS=1 one cycle after transfer. E high exactly 3 cycles, starting 2 cycles after transfer. in_ready returns 11 cycles after transfer. nib_count=1.
3. Send 0x20 (RS=0) -> same strobe shape; in_ready returns 26 cycles after transfer.
4. Send 0x71 (bit0=1) -> no E pulse; DQ/RS unchanged; in_ready stays 1; nib_count unchanged.
5. Assert nreset while E is high -> lcd_e=0 immediately, outputs reach reset values, and a full 10-cycle PWRUP wait follows.
6. Macro defined -> after PWRUP, four E pulses carrying DQ 3,3,3,2 with RS=0, each followed by a 20-cycle wait; then in_ready=1 and nib_count=4.
